// File: rtl/vai_mgr_csr.sv
// rtl/vai_mgr_csr.sv - Manager CSR block for the VAI mux: MMIO decode, sub-AFU offsets, enables, reset pulses
// Optional per-sub-AFU RESET write counters at 0x200 are built when VAI_MGR_RSTCNT_EN is defined.
module vai_mgr_csr #(
   parameter int           NUM_SUB_AFUS = 8,
   parameter int           RESET_CYCLES = 16,
   parameter logic [127:0] MGR_ID       = 128'hd1d383aaca4c4c60a0a013a421139e69
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          mmio_rd_valid,
   input  logic                          mmio_wr_valid,
   input  logic [15:0]                   mmio_addr,
   input  logic [8:0]                    mmio_tid,
   input  logic [63:0]                   mmio_wdata,
   output logic                          rsp_valid,
   output logic [8:0]                    rsp_tid,
   output logic [63:0]                   rsp_data,
   output logic [NUM_SUB_AFUS-1:0][63:0] offset_array,
   output logic [NUM_SUB_AFUS-1:0]       sub_afu_enable,
   output logic [NUM_SUB_AFUS-1:0]       sub_afu_reset
);
   typedef enum logic [3:0] {
      K_NONE, K_DFH, K_IDLO, K_IDHI, K_RST, K_EN, K_INFO, K_OFF, K_CNT
   } kind_t;

   logic        s1_rd, s1_wr;
   logic [15:0] s1_addr;
   logic [8:0]  s1_tid;
   logic [63:0] s1_wdata;

   logic        s2_rd, s2_wr;
   kind_t       s2_kind;
   logic [5:0]  s2_idx;
   logic [8:0]  s2_tid;
   logic [63:0] s2_wdata;

   kind_t       dec_kind;
   logic [5:0]  dec_idx;
   logic        idx_ok;
   logic [63:0] rd_data;

   logic [NUM_SUB_AFUS-1:0][15:0] cnt;
`ifdef VAI_MGR_RSTCNT_EN
   logic [NUM_SUB_AFUS-1:0][31:0] rst_count;
`endif

   // T1: capture request; a simultaneous read is dropped in favour of the write
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_rd    <= 1'b0;
         s1_wr    <= 1'b0;
         s1_addr  <= '0;
         s1_tid   <= '0;
         s1_wdata <= '0;
      end else begin
         s1_rd    <= mmio_rd_valid & ~mmio_wr_valid;
         s1_wr    <= mmio_wr_valid;
         s1_addr  <= mmio_addr;
         s1_tid   <= mmio_tid;
         s1_wdata <= mmio_wdata;
      end
   end

   assign idx_ok = ({26'd0, s1_addr[6:1]} < NUM_SUB_AFUS);

   always_comb begin
      dec_kind = K_NONE;
      dec_idx  = s1_addr[6:1];
      if (!s1_addr[0]) begin
         if (s1_addr[15:7] == 9'd0) begin
            case (s1_addr[6:1])
               6'd0:    dec_kind = K_DFH;
               6'd1:    dec_kind = K_IDLO;
               6'd2:    dec_kind = K_IDHI;
               6'd3:    dec_kind = K_RST;
               6'd4:    dec_kind = K_EN;
               6'd5:    dec_kind = K_INFO;
               default: dec_kind = K_NONE;
            endcase
         end else if (s1_addr[15:7] == 9'd2 && idx_ok) begin
            dec_kind = K_OFF;
         end
`ifdef VAI_MGR_RSTCNT_EN
         else if (s1_addr[15:7] == 9'd4 && idx_ok) begin
            dec_kind = K_CNT;
         end
`endif
      end
   end

   // T2: registered decode
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_rd    <= 1'b0;
         s2_wr    <= 1'b0;
         s2_kind  <= K_NONE;
         s2_idx   <= '0;
         s2_tid   <= '0;
         s2_wdata <= '0;
      end else begin
         s2_rd    <= s1_rd;
         s2_wr    <= s1_wr;
         s2_kind  <= dec_kind;
         s2_idx   <= dec_idx;
         s2_tid   <= s1_tid;
         s2_wdata <= s1_wdata;
      end
   end

   // Read data is taken from live registers at T3 so a read right behind a write sees the new value
   always_comb begin
      rd_data = '1;
      case (s2_kind)
         K_DFH:   rd_data = 64'h1000_0100_0000_0000;
         K_IDLO:  rd_data = MGR_ID[63:0];
         K_IDHI:  rd_data = MGR_ID[127:64];
         K_RST:   rd_data = 64'(sub_afu_reset);
         K_EN:    rd_data = 64'(sub_afu_enable);
         K_INFO:  rd_data = {32'd0, 16'(RESET_CYCLES), 16'(NUM_SUB_AFUS)};
         K_OFF: begin
            for (int i = 0; i < NUM_SUB_AFUS; i++)
               if (s2_idx == 6'(i)) rd_data = offset_array[i];
         end
`ifdef VAI_MGR_RSTCNT_EN
         K_CNT: begin
            for (int i = 0; i < NUM_SUB_AFUS; i++)
               if (s2_idx == 6'(i)) rd_data = {32'd0, rst_count[i]};
         end
`endif
         default: rd_data = '1;
      endcase
   end

   // T3: commit writes, form response, run reset pulse counters
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid      <= 1'b0;
         rsp_tid        <= '0;
         rsp_data       <= '0;
         offset_array   <= '0;
         sub_afu_enable <= '0;
         cnt            <= '0;
      end else begin
         rsp_valid <= s2_rd;
         rsp_tid   <= s2_rd ? s2_tid : 9'd0;
         rsp_data  <= s2_rd ? rd_data : 64'd0;
         for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            if (s2_wr && s2_kind == K_RST && s2_wdata[i])
               cnt[i] <= 16'(RESET_CYCLES);
            else if (cnt[i] != 16'd0)
               cnt[i] <= cnt[i] - 16'd1;
            if (s2_wr && s2_kind == K_OFF && s2_idx == 6'(i))
               offset_array[i] <= s2_wdata;
         end
         if (s2_wr && s2_kind == K_EN)
            sub_afu_enable <= s2_wdata[NUM_SUB_AFUS-1:0];
      end
   end

   always_comb begin
      sub_afu_reset = '0;
      for (int i = 0; i < NUM_SUB_AFUS; i++)
         sub_afu_reset[i] = (cnt[i] != 16'd0);
   end

`ifdef VAI_MGR_RSTCNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rst_count <= '0;
      end else begin
         for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            if (s2_wr && s2_kind == K_CNT && s2_idx == 6'(i))
               rst_count[i] <= 32'd0;
            else if (s2_wr && s2_kind == K_RST && s2_wdata[i] && rst_count[i] != 32'hFFFF_FFFF)
               rst_count[i] <= rst_count[i] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vai_mgr_csr.sv
// tb/tb_vai_mgr_csr.sv - Self-checking bench for vai_mgr_csr
module tb_vai_mgr_csr;
   localparam int           N    = 8;
   localparam int           RC   = 16;
   localparam logic [127:0] GUID = 128'hd1d383aaca4c4c60a0a013a421139e69;
`ifdef VAI_MGR_RSTCNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif
   localparam int UNM = 0, DFH = 1, IDLO = 2, IDHI = 3, RST = 4, EN = 5, INFO = 6, OFF = 7, CNT = 8;
   localparam int NT  = 14;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                mmio_rd_valid = 1'b0;
   logic                mmio_wr_valid = 1'b0;
   logic [15:0]         mmio_addr = '0;
   logic [8:0]          mmio_tid = '0;
   logic [63:0]         mmio_wdata = '0;
   logic                rsp_valid;
   logic [8:0]          rsp_tid;
   logic [63:0]         rsp_data;
   logic [N-1:0][63:0]  offset_array;
   logic [N-1:0]        sub_afu_enable;
   logic [N-1:0]        sub_afu_reset;

   vai_mgr_csr #(.NUM_SUB_AFUS(N), .RESET_CYCLES(RC), .MGR_ID(GUID)) dut (
      .clk(clk), .reset(reset),
      .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
      .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
      .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
      .offset_array(offset_array), .sub_afu_enable(sub_afu_enable), .sub_afu_reset(sub_afu_reset)
   );

   always #5 clk = ~clk;

   typedef struct { int due; int kind; int idx; logic [63:0] val; } wr_t;
   typedef struct { int due; logic [8:0] tid; logic [63:0] data; } rsp_t;
   typedef struct { logic [15:0] addr; logic [63:0] data; } vec_t;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   logic [63:0] m_off [N];
   logic [63:0] v_off [N];
   logic [63:0] m_en, v_en;
   longint      m_cnt [N];
   int          r_start [N];
   int          r_end [N];
   int          hi_cnt [N];
   wr_t         pend [$];
   rsp_t        exq [$];
   rsp_t        got [$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endfunction

   function automatic void decode(input logic [15:0] a, output int kind, output int idx);
      int w;
      w = {16'd0, a};
      kind = UNM;
      idx = 0;
      if (w % 2 == 0) begin
         case (w)
            'h000:   kind = DFH;
            'h002:   kind = IDLO;
            'h004:   kind = IDHI;
            'h006:   kind = RST;
            'h008:   kind = EN;
            'h00A:   kind = INFO;
            default: kind = UNM;
         endcase
         if (w >= 'h100 && w < 'h100 + 2 * N) begin kind = OFF; idx = (w - 'h100) / 2; end
         if (CNT_ON && w >= 'h200 && w < 'h200 + 2 * N) begin kind = CNT; idx = (w - 'h200) / 2; end
      end
   endfunction

   // Architectural value of a register as seen by a read issued at cycle n
   function automatic logic [63:0] model_read(int kind, int idx, int n);
      logic [63:0] v;
      v = '1;
      case (kind)
         DFH:  v = 64'h1000_0100_0000_0000;
         IDLO: v = GUID[63:0];
         IDHI: v = GUID[127:64];
         RST: begin
            v = 0;
            for (int i = 0; i < N; i++) if (r_start[i] <= n + 2 && n + 2 < r_end[i]) v[i] = 1'b1;
         end
         EN:   v = m_en;
         INFO: v = (64'(RC) << 16) | 64'(N);
         OFF:  v = m_off[idx];
         CNT:  v = 64'(m_cnt[idx]);
         default: v = '1;
      endcase
      return v;
   endfunction

   task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [8:0] tid,
                        input logic [63:0] wd);
      int kind, idx, n;
      n = cyc;
      decode(a, kind, idx);
      mmio_rd_valid = rd;
      mmio_wr_valid = wr;
      mmio_addr = a;
      mmio_tid = tid;
      mmio_wdata = wd;
      if (wr) begin
         case (kind)
            RST: for (int i = 0; i < N; i++) if (wd[i]) begin
               if (r_end[i] < n + 3) r_start[i] = n + 3;
               r_end[i] = n + 3 + RC;
               if (m_cnt[i] < 64'd4294967295) m_cnt[i]++;
            end
            EN: begin
               m_en = wd & ((64'd1 << N) - 64'd1);
               pend.push_back('{n + 3, EN, 0, m_en});
            end
            OFF: begin
               m_off[idx] = wd;
               pend.push_back('{n + 3, OFF, idx, wd});
            end
            CNT: m_cnt[idx] = 0;
            default: ;
         endcase
      end else if (rd) begin
         exq.push_back('{n + 3, tid, model_read(kind, idx, n)});
      end
      @(posedge clk); #1;
      mmio_rd_valid = 1'b0;
      mmio_wr_valid = 1'b0;
   endtask

   task automatic idle(input int k);
      mmio_rd_valid = 1'b0;
      mmio_wr_valid = 1'b0;
      repeat (k) begin @(posedge clk); #1; end
   endtask

   task automatic apply_reset();
      mmio_rd_valid = 1'b0;
      mmio_wr_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      pend.delete();
      exq.delete();
      for (int i = 0; i < N; i++) begin
         m_off[i] = 0; v_off[i] = 0; m_cnt[i] = 0; r_start[i] = 0; r_end[i] = 0;
      end
      m_en = 0;
      v_en = 0;
      chk_en = 1'b1;
      reset = 1'b0;
   endtask

   // Continuous output checks against the model, one sample per cycle away from the active edge
   always @(negedge clk) if (chk_en) begin
      logic [63:0] er;
      while (pend.size() > 0 && pend[0].due <= cyc) begin
         if (pend[0].kind == EN) v_en = pend[0].val;
         else v_off[pend[0].idx] = pend[0].val;
         void'(pend.pop_front());
      end
      er = 0;
      for (int i = 0; i < N; i++) er[i] = (r_start[i] <= cyc && cyc < r_end[i]);
      check("sub_afu_reset", 64'(sub_afu_reset), er);
      check("sub_afu_enable", 64'(sub_afu_enable), v_en);
      for (int i = 0; i < N; i++) check($sformatf("offset_array[%0d]", i), offset_array[i], v_off[i]);
      if (exq.size() > 0 && exq[0].due == cyc) begin
         check("rsp_valid", 64'(rsp_valid), 64'd1);
         check("rsp_tid", 64'(rsp_tid), 64'(exq[0].tid));
         check("rsp_data", rsp_data, exq[0].data);
         void'(exq.pop_front());
      end else begin
         check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
         check("rsp_data_idle", rsp_data, 64'd0);
         check("rsp_tid_idle", 64'(rsp_tid), 64'd0);
      end
      if (rsp_valid === 1'b1) got.push_back('{cyc, rsp_tid, rsp_data});
      for (int i = 0; i < N; i++) if (sub_afu_reset[i] === 1'b1) hi_cnt[i]++;
   end

   initial begin
      vec_t        tbl [NT];
      logic [15:0] a;
      logic [63:0] wd;
      int          s, q, sum;
      tbl[0]  = '{16'h000, 64'h1000_0100_0000_0000};
      tbl[1]  = '{16'h002, 64'ha0a013a421139e69};
      tbl[2]  = '{16'h004, 64'hd1d383aaca4c4c60};
      tbl[3]  = '{16'h006, 64'd0};
      tbl[4]  = '{16'h008, 64'd0};
      tbl[5]  = '{16'h00A, {32'd0, 16'(RC), 16'(N)}};
      tbl[6]  = '{16'h003, '1};
      tbl[7]  = '{16'h001, '1};
      tbl[8]  = '{16'h00C, '1};
      tbl[9]  = '{16'(256 + 2 * N), '1};
      tbl[10] = '{16'h108, 64'd0};
      tbl[11] = '{16'h17F, '1};
      tbl[12] = '{16'h204, CNT_ON ? 64'd0 : '1};
      tbl[13] = '{16'hFFFE, '1};

      apply_reset();
      idle(2);

      got.delete();
      for (int i = 0; i < NT; i++) issue(1'b1, 1'b0, tbl[i].addr, 9'(i + 1), 64'd0);
      idle(5);
      check("table_rsp_count", 64'(got.size()), 64'(NT));
      for (int i = 0; i < NT; i++) if (i < got.size()) begin
         check($sformatf("table_tid[%0d]", i), 64'(got[i].tid), 64'(i + 1));
         check($sformatf("table_data[%0h]", tbl[i].addr), got[i].data, tbl[i].data);
      end
      if (got.size() >= 3) check("table_latency", 64'(got[2].due - got[0].due), 64'd2);

      got.delete();
      issue(1'b0, 1'b1, 16'h106, 9'd0, 64'hDEAD_BEEF_0000_1000);
      issue(1'b1, 1'b0, 16'h106, 9'h55, 64'd0);
      idle(4);
      check("offset3_out", offset_array[3], 64'hDEAD_BEEF_0000_1000);
      check("offset3_rsp_count", 64'(got.size()), 64'd1);
      if (got.size() > 0) check("offset3_rd", got[0].data, 64'hDEAD_BEEF_0000_1000);

      for (int i = 0; i < N; i++) hi_cnt[i] = 0;
      issue(1'b0, 1'b1, 16'h006, 9'd0, 64'h5);
      idle(9);
      issue(1'b0, 1'b1, 16'h006, 9'd0, 64'h1);
      idle(40);
      check("pulse_bit0_len", 64'(hi_cnt[0]), 64'd26);
      check("pulse_bit2_len", 64'(hi_cnt[2]), 64'd16);
      check("pulse_bit1_len", 64'(hi_cnt[1]), 64'd0);

      for (int i = 0; i < N; i++) hi_cnt[i] = 0;
      got.delete();
      issue(1'b0, 1'b1, 16'h006, 9'd0, 64'd1 << N);
      issue(1'b1, 1'b0, 16'h006, 9'd9, 64'd0);
      idle(25);
      sum = 0;
      for (int i = 0; i < N; i++) sum += hi_cnt[i];
      check("reset_hi_bit_ignored", 64'(sum), 64'd0);
      if (got.size() > 0) check("reset_read_after_hi_bit", got[0].data, 64'd0);

      got.delete();
      issue(1'b0, 1'b1, 16'h006, 9'd0, '1);
      issue(1'b0, 1'b1, 16'h008, 9'd0, 64'hAA);
      issue(1'b0, 1'b1, 16'h102, 9'd0, 64'h1234);
      issue(1'b1, 1'b0, 16'h002, 9'h1AA, 64'd0);
      apply_reset();
      check("mid_reset_pulse", 64'(sub_afu_reset), 64'd0);
      idle(6);
      check("mid_reset_no_rsp", 64'(got.size()), 64'd0);
      check("mid_reset_enable", 64'(sub_afu_enable), 64'd0);
      check("mid_reset_offset1", offset_array[1], 64'd0);

      got.delete();
      repeat (3) issue(1'b0, 1'b1, 16'h006, 9'd0, 64'h4);
      issue(1'b1, 1'b0, 16'h204, 9'd7, 64'd0);
      idle(4);
      issue(1'b0, 1'b1, 16'h204, 9'd0, 64'd0);
      issue(1'b1, 1'b0, 16'h204, 9'd8, 64'd0);
      idle(4);
      check("rstcnt_rsp_count", 64'(got.size()), 64'd2);
      if (got.size() > 0) check("rstcnt2_after_3", got[0].data, CNT_ON ? 64'd3 : '1);
      if (got.size() > 1) check("rstcnt2_cleared", got[1].data, CNT_ON ? 64'd0 : '1);
      idle(20);

      for (int k = 0; k < 2500; k++) begin
         q = $urandom_range(0, 999);
         if (q < 4) apply_reset();
         else if (q < 200) idle(1);
         else begin
            s = $urandom_range(0, 15);
            if (s < 3) a = 16'(2 * $urandom_range(0, 6));
            else if (s < 9) a = 16'(256 + 2 * $urandom_range(0, N));
            else if (s < 11) a = 16'(512 + 2 * $urandom_range(0, N));
            else if (s == 11) a = 16'($urandom);
            else if (s == 12) a = 16'(2 * $urandom_range(0, 511) + 1);
            else a = 16'h008;
            wd = {$urandom, $urandom};
            q = $urandom_range(0, 99);
            if (a == 16'h006 && $urandom_range(0, 3) != 0) q = 0;
            if (q < 45) issue(1'b1, 1'b0, a, 9'($urandom), wd);
            else if (q < 95) issue(1'b0, 1'b1, a, 9'($urandom), wd);
            else issue(1'b1, 1'b1, a, 9'($urandom), wd);
         end
      end
      idle(RC + 6);
      check("final_rsp_queue_empty", 64'(exq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
